// File: rtl/ras_stack.sv
// Return-address stack: circular buffer of DEPTH entries with a registered pop response.
// Optional checkpoint/restore of {tos,count} is enabled by defining RAS_CKPT_EN.
module ras_stack #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_push,
    input  logic            req_pop,
    input  logic [XLEN-1:0] req_addr,
    output logic            rsp_valid,
    output logic            rsp_hit,
    output logic [XLEN-1:0] rsp_addr,
    output logic [AW:0]     count,
    output logic            empty,
    output logic            full,
    output logic            ovf_sticky,
    input  logic            ckpt_save,
    input  logic            ckpt_restore
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = (AW)'(1);

    logic [XLEN-1:0] mem_q [DEPTH];

    logic [AW-1:0]   tos_q, tos_d;
    logic [AW:0]     count_q, count_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_hit_q, rsp_hit_d;
    logic [XLEN-1:0] rsp_addr_q, rsp_addr_d;
    logic            ovf_q, ovf_d;
    logic            ready_q, ready_d;
    logic            empty_q, empty_d;
    logic            full_q, full_d;

    logic            accept_s;
    logic            restore_s;
    logic [AW-1:0]   top_idx_s;
    logic            wr_en_s;
    logic [AW-1:0]   wr_idx_s;
    logic [XLEN-1:0] wr_data_s;
    logic [AW-1:0]   snap_tos_s;
    logic [AW:0]     snap_cnt_s;

    assign accept_s  = req_valid & ready_q;
    assign top_idx_s = tos_q - PTR_ONE;

`ifdef RAS_CKPT_EN
    logic [AW-1:0] snap_tos_q, snap_tos_d;
    logic [AW:0]   snap_cnt_q, snap_cnt_d;

    assign restore_s  = ckpt_restore;
    assign snap_tos_s = snap_tos_q;
    assign snap_cnt_s = snap_cnt_q;

    // Snapshot captures pre-edge pointers; a same-edge restore leaves it untouched.
    always_comb begin
        snap_tos_d = snap_tos_q;
        snap_cnt_d = snap_cnt_q;
        if (ckpt_save && !ckpt_restore) begin
            snap_tos_d = tos_q;
            snap_cnt_d = count_q;
        end else begin
            snap_tos_d = snap_tos_q;
            snap_cnt_d = snap_cnt_q;
        end
    end

    // Snapshot register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_tos_q <= {AW{1'b0}};
            snap_cnt_q <= {(AW+1){1'b0}};
        end else begin
            snap_tos_q <= snap_tos_d;
            snap_cnt_q <= snap_cnt_d;
        end
    end
`else
    logic unused_ckpt_s;

    assign unused_ckpt_s = ckpt_save ^ ckpt_restore;
    assign restore_s     = 1'b0;
    assign snap_tos_s    = {AW{1'b0}};
    assign snap_cnt_s    = {(AW+1){1'b0}};
`endif

    // Next-state: flush beats restore beats the request; memory is read before the same-edge write.
    always_comb begin
        tos_d       = tos_q;
        count_d     = count_q;
        rsp_valid_d = 1'b0;
        rsp_hit_d   = rsp_hit_q;
        rsp_addr_d  = rsp_addr_q;
        ovf_d       = ovf_q;
        ready_d     = 1'b1;
        wr_en_s     = 1'b0;
        wr_idx_s    = tos_q;
        wr_data_s   = req_addr;
        if (flush) begin
            tos_d   = {AW{1'b0}};
            count_d = {(AW+1){1'b0}};
            ovf_d   = 1'b0;
        end else if (restore_s) begin
            tos_d   = snap_tos_s;
            count_d = snap_cnt_s;
            ovf_d   = 1'b0;
            ready_d = 1'b0;
        end else if (accept_s) begin
            case ({req_push, req_pop})
                2'b10: begin
                    wr_en_s = 1'b1;
                    tos_d   = tos_q + PTR_ONE;
                    if (count_q == FULL_CNT) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
                2'b01: begin
                    rsp_valid_d = 1'b1;
                    if (count_q != {(AW+1){1'b0}}) begin
                        rsp_hit_d  = 1'b1;
                        rsp_addr_d = mem_q[top_idx_s];
                        tos_d      = top_idx_s;
                        count_d    = count_q - CNT_ONE;
                    end else begin
                        rsp_hit_d  = 1'b0;
                        rsp_addr_d = {XLEN{1'b0}};
                    end
                end
                2'b11: begin
                    rsp_valid_d = 1'b1;
                    wr_en_s     = 1'b1;
                    if (count_q != {(AW+1){1'b0}}) begin
                        // Coroutine swap: replace the top entry in place.
                        rsp_hit_d  = 1'b1;
                        rsp_addr_d = mem_q[top_idx_s];
                        wr_idx_s   = top_idx_s;
                    end else begin
                        rsp_hit_d  = 1'b0;
                        rsp_addr_d = {XLEN{1'b0}};
                        tos_d      = tos_q + PTR_ONE;
                        count_d    = CNT_ONE;
                    end
                end
                default: begin
                    tos_d = tos_q;
                end
            endcase
        end else begin
            tos_d = tos_q;
        end
        empty_d = (count_d == {(AW+1){1'b0}});
        full_d  = (count_d == FULL_CNT);
    end

    // Control and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tos_q       <= {AW{1'b0}};
            count_q     <= {(AW+1){1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_addr_q  <= {XLEN{1'b0}};
            ovf_q       <= 1'b0;
            ready_q     <= 1'b0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
        end else begin
            tos_q       <= tos_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_addr_q  <= rsp_addr_d;
            ovf_q       <= ovf_d;
            ready_q     <= ready_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
        end
    end

    // Entry storage; contents survive flush and reset but become unreachable.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_s) begin
            mem_q[wr_idx_s] <= wr_data_s;
        end
    end

    assign req_ready  = ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_hit    = rsp_hit_q;
    assign rsp_addr   = rsp_addr_q;
    assign count      = count_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign ovf_sticky = ovf_q;

endmodule
